// File: rtl/audio_i2s_tx.sv
// ---------------------------------------------------------------------------
// audio_i2s_tx
//
// Buffers 8-bit unsigned audio samples in a small FIFO and serialises them as
// a Philips-I2S stream (bclk / lrck / sdata). The same sample is sent on both
// the left and the right channel. Everything runs on the single system clock;
// the bit clock is a divided register output, not a separate clock domain.
//
// Ports:
//   clock         in   system clock (50 MHz)
//   reset_n       in   asynchronous active-low reset
//   sample_in     in   unsigned offset-binary sample, 0x80 = midscale
//   sample_valid  in   push request
//   sample_ready  out  FIFO not full
//   underrun      out  one-clock pulse: a frame started with the FIFO empty
//   i2s_bclk      out  bit clock
//   i2s_lrck      out  word select, 0 = left, 1 = right
//   i2s_sdata     out  serial data, MSB first, one bclk behind lrck
//   volume        in   attenuation shift (only with AUDIO_I2S_VOLUME_EN)
//
// Optional feature macro: AUDIO_I2S_VOLUME_EN
//   Defined     -> volume port exists; the word is arithmetically shifted
//                  right by volume when it is loaded at frame start.
//   Not defined -> no volume port; the word is loaded unshifted.
// ---------------------------------------------------------------------------
module audio_i2s_tx #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int SLOT_BITS    = 16,
    parameter int BCLK_HALF    = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    underrun,
    output logic                    i2s_bclk,
    output logic                    i2s_lrck,
    output logic                    i2s_sdata
`ifdef AUDIO_I2S_VOLUME_EN
    ,
    input  logic [2:0]              volume
`endif
);

    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_BITS);
    localparam int SEL_W = $clog2(SLOT_BITS);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [DIV_W-1:0]        DIV_LAST  = DIV_W'(BCLK_HALF - 1);
    localparam logic [BIT_W-1:0]        BIT_LAST  = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0]        SLOT_LEN  = BIT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0]        CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [SAMPLE_WIDTH-1:0] SIGN_FLIP = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    logic [SAMPLE_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wrPtr;
    logic [PTR_W-1:0]        r_rdPtr;
    logic [CNT_W-1:0]        r_count;
    logic [DIV_W-1:0]        r_divCnt;
    logic                    r_bclk;
    logic [BIT_W-1:0]        r_bitCnt;
    logic                    r_lrck;
    logic                    r_sdata;
    logic [SLOT_BITS-1:0]    r_word;
    logic                    r_underrun;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_tick;
    logic                    w_fall;
    logic                    w_frameStart;
    logic [BIT_W-1:0]        w_bitNext;
    logic [BIT_W-1:0]        w_posNext;
    logic [SEL_W-1:0]        w_sel;
    logic                    w_sdataNext;
    logic [SLOT_BITS-1:0]    w_wordRaw;
    logic [SLOT_BITS-1:0]    w_wordLoad;

    // FIFO flags and handshakes. Pop and the empty test both use the count
    // before this cycle's push, so a push that coincides with a frame start
    // still lets that frame report underrun.
    assign w_full       = (r_count == CNT_FULL);
    assign w_empty      = (r_count == '0);
    assign w_push       = sample_valid && !w_full;
    assign w_pop        = w_frameStart && !w_empty;
    assign sample_ready = !w_full;

    // Bit-clock timing: a tick every BCLK_HALF clocks toggles bclk; a tick
    // while bclk is high is the falling edge where the serial state advances.
    assign w_tick       = (r_divCnt == DIV_LAST);
    assign w_fall       = w_tick && r_bclk;
    assign w_bitNext    = (r_bitCnt == BIT_LAST) ? '0 : r_bitCnt + BIT_W'(1);
    assign w_frameStart = w_fall && (w_bitNext == '0);

    // Slot position 0 carries the I2S one-bit delay; positions 1.. carry
    // word[SLOT_BITS-p]. The select truncates harmlessly at p==0.
    assign w_posNext   = (w_bitNext >= SLOT_LEN) ? w_bitNext - SLOT_LEN : w_bitNext;
    assign w_sel       = SEL_W'(SLOT_LEN - w_posNext);
    assign w_sdataNext = (w_posNext == '0) ? 1'b0 : r_word[w_sel];

    // Offset-binary to left-aligned two's complement by flipping the MSB.
    assign w_wordRaw = {r_fifo[r_rdPtr] ^ SIGN_FLIP, {(SLOT_BITS-SAMPLE_WIDTH){1'b0}}};

`ifdef AUDIO_I2S_VOLUME_EN
    logic signed [SLOT_BITS-1:0] w_wordSigned;
    assign w_wordSigned = w_wordRaw;
    assign w_wordLoad   = w_wordSigned >>> volume;
`else
    assign w_wordLoad = w_wordRaw;
`endif

    // Sample storage is not reset; only the pointers and count define content.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wrPtr] <= sample_in;
        end
    end

    // FIFO pointers and occupancy. Simultaneous push and pop leave the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Bit-clock divider and the serial shifter. lrck and sdata change on the
    // falling bclk edge so the codec samples them stable on the rising edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_divCnt <= '0;
            r_bclk   <= 1'b0;
            r_bitCnt <= '0;
            r_lrck   <= 1'b0;
            r_sdata  <= 1'b0;
        end else begin
            if (w_tick) begin
                r_divCnt <= '0;
                r_bclk   <= ~r_bclk;
            end else begin
                r_divCnt <= r_divCnt + DIV_W'(1);
            end
            if (w_fall) begin
                r_bitCnt <= w_bitNext;
                r_lrck   <= (w_bitNext >= SLOT_LEN);
                r_sdata  <= w_sdataNext;
            end
        end
    end

    // Hold word is refreshed only at frame start; on an empty FIFO the old
    // word is replayed and underrun pulses for one clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_word     <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_frameStart && w_empty;
            if (w_pop) begin
                r_word <= w_wordLoad;
            end
        end
    end

    assign i2s_bclk  = r_bclk;
    assign i2s_lrck  = r_lrck;
    assign i2s_sdata = r_sdata;
    assign underrun  = r_underrun;

endmodule
